// File: rtl/snake_collision_scanner_pkg.sv
// Shared geometry, sizing and FSM encoding for the snake collision scanner.
package snake_collision_scanner_pkg;
    localparam int SEG_W    = 10;
    localparam int MAX_SEG  = 100;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int IDX_W    = 7;
    localparam int LEN_W    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

    // Body slots are 1..max_seg-1, so longer requested lengths saturate there.
    function automatic logic [IDX_W-1:0] clamp_length(input logic [LEN_W-1:0] len,
                                                      input int max_seg);
        if (int'(len) > max_seg - 1) return IDX_W'(max_seg - 1);
        return IDX_W'(len);
    endfunction
endpackage

// File: rtl/snake_collision_scanner_if.sv
// Snake position buses, food, and the scan request/result handshake.
interface snake_collision_scanner_if #(
    parameter int SEG_W   = snake_collision_scanner_pkg::SEG_W,
    parameter int MAX_SEG = snake_collision_scanner_pkg::MAX_SEG
);
    import snake_collision_scanner_pkg::*;

    logic [SEG_W*MAX_SEG-1:0] pos_x;
    logic [SEG_W*MAX_SEG-1:0] pos_y;
    logic [LEN_W-1:0]         length;
    logic [SEG_W-1:0]         food_x;
    logic [SEG_W-1:0]         food_y;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     self_hit;
    logic                     food_hit;
    logic [IDX_W-1:0]         hit_index;

    modport master (
        output pos_x, pos_y, length, food_x, food_y, start,
        input  busy, done, self_hit, food_hit, hit_index
    );

    modport slave (
        input  pos_x, pos_y, length, food_x, food_y, start,
        output busy, done, self_hit, food_hit, hit_index
    );
endinterface

// File: rtl/snake_segment_select.sv
// Combinational pick of one segment's X/Y out of the packed position buses.
module snake_segment_select #(
    parameter int SEG_W   = 10,
    parameter int MAX_SEG = 100,
    parameter int IDX_W   = 7
) (
    input  logic [SEG_W*MAX_SEG-1:0] pos_x,
    input  logic [SEG_W*MAX_SEG-1:0] pos_y,
    input  logic [IDX_W-1:0]         idx,
    output logic [SEG_W-1:0]         seg_x,
    output logic [SEG_W-1:0]         seg_y
);
    always_comb begin
        seg_x = '0;
        seg_y = '0;
        if (int'(idx) < MAX_SEG) begin
            seg_x = pos_x[int'(idx)*SEG_W +: SEG_W];
            seg_y = pos_y[int'(idx)*SEG_W +: SEG_W];
        end
    end
endmodule

// File: rtl/snake_collision_scanner.sv
// Walks the snake body one segment per clock looking for the head, and checks
// the head against the food; results hold until the next accepted start.
module snake_collision_scanner #(
    parameter int SEG_W   = snake_collision_scanner_pkg::SEG_W,
    parameter int MAX_SEG = snake_collision_scanner_pkg::MAX_SEG
) (
    input  logic                       clock,
    input  logic                       reset_n,
    snake_collision_scanner_if.slave   bus
);
    import snake_collision_scanner_pkg::*;

    scan_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] len_clamp;
    logic [SEG_W-1:0] head_x, head_y;
    logic [SEG_W-1:0] food_x_q, food_y_q;
    logic [SEG_W-1:0] seg_x, seg_y;
    logic             seg_match;

    assign len_clamp = clamp_length(bus.length, MAX_SEG);
    assign seg_match = (seg_x == head_x) && (seg_y == head_y);

    snake_segment_select #(
        .SEG_W   (SEG_W),
        .MAX_SEG (MAX_SEG),
        .IDX_W   (IDX_W)
    ) u_segment_select (
        .pos_x (bus.pos_x),
        .pos_y (bus.pos_y),
        .idx   (idx),
        .seg_x (seg_x),
        .seg_y (seg_y)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            len_q         <= '0;
            head_x        <= '0;
            head_y        <= '0;
            food_x_q      <= '0;
            food_y_q      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.self_hit  <= 1'b0;
            bus.food_hit  <= 1'b0;
            bus.hit_index <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        head_x        <= bus.pos_x[SEG_W-1:0];
                        head_y        <= bus.pos_y[SEG_W-1:0];
                        food_x_q      <= bus.food_x;
                        food_y_q      <= bus.food_y;
                        len_q         <= len_clamp;
                        idx           <= IDX_W'(1);
                        bus.busy      <= 1'b1;
                        bus.self_hit  <= 1'b0;
                        bus.food_hit  <= 1'b0;
                        bus.hit_index <= '0;
                        state         <= (len_clamp == '0) ? REPORT : SCAN;
                    end
                end
                // The body bus is read live here; the first matching index wins.
                SCAN: begin
                    if (seg_match) begin
                        bus.self_hit  <= 1'b1;
                        bus.hit_index <= idx;
                        state         <= REPORT;
                    end else if (idx == len_q) begin
                        state <= REPORT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                REPORT: begin
                    bus.food_hit <= (head_x == food_x_q) && (head_y == food_y_q);
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_collision_scanner.sv
// Scoreboard bench for snake_collision_scanner: each start pushes the modelled
// result and latency, which are popped and compared when done appears.
module tb_snake_collision_scanner;
    import snake_collision_scanner_pkg::*;

    localparam int BUDGET = 150;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    snake_collision_scanner_if #(.SEG_W(SEG_W), .MAX_SEG(MAX_SEG)) bus();

    snake_collision_scanner #(.SEG_W(SEG_W), .MAX_SEG(MAX_SEG)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int self_hit;
        int food_hit;
        int hit_index;
        int latency;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   sx[MAX_SEG];
    int   sy[MAX_SEG];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int hx, input int hy, input int bx, input int by);
        sx[0] = hx;
        sy[0] = hy;
        for (int k = 1; k < MAX_SEG; k++) begin
            sx[k] = bx;
            sy[k] = by;
        end
    endtask

    task automatic load_bus();
        logic [SEG_W*MAX_SEG-1:0] vx;
        logic [SEG_W*MAX_SEG-1:0] vy;
        for (int k = 0; k < MAX_SEG; k++) begin
            vx[k*SEG_W +: SEG_W] = SEG_W'(sx[k]);
            vy[k*SEG_W +: SEG_W] = SEG_W'(sy[k]);
        end
        bus.pos_x = vx;
        bus.pos_y = vy;
    endtask

    function automatic exp_t model(input int len, input int fx, input int fy);
        exp_t e;
        int   lp;
        lp          = (len > MAX_SEG - 1) ? MAX_SEG - 1 : len;
        e.self_hit  = 0;
        e.hit_index = 0;
        e.food_hit  = (sx[0] == fx && sy[0] == fy) ? 1 : 0;
        e.latency   = lp + 1;
        for (int k = 1; k <= lp; k++) begin
            if (sx[k] == sx[0] && sy[k] == sy[0]) begin
                e.self_hit  = 1;
                e.hit_index = k;
                e.latency   = k + 1;
                break;
            end
        end
        return e;
    endfunction

    task automatic run_scan(input string tag, input int len, input int fx, input int fy,
                            input int extra_start_at);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clock);
        load_bus();
        bus.length = LEN_W'(len);
        bus.food_x = SEG_W'(fx);
        bus.food_y = SEG_W'(fy);
        sb_q.push_back(model(len, fx, fy));
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check({tag, "/busy_on"}, 32'(bus.busy), 32'(1));
        check({tag, "/cleared"}, 32'({bus.self_hit, bus.food_hit, bus.hit_index}), 32'(0));
        n    = 0;
        seen = 1'b0;
        while (!seen && n < BUDGET) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.done) seen = 1'b1;
            bus.start = (n == extra_start_at);
        end
        bus.start = 1'b0;
        check({tag, "/done_seen"}, 32'(seen), 32'(1));
        e = sb_q.pop_front();
        if (seen) begin
            check({tag, "/latency"},   32'(n),             32'(e.latency));
            check({tag, "/self_hit"},  32'(bus.self_hit),  32'(e.self_hit));
            check({tag, "/food_hit"},  32'(bus.food_hit),  32'(e.food_hit));
            check({tag, "/hit_index"}, 32'(bus.hit_index), 32'(e.hit_index));
            check({tag, "/busy_off"},  32'(bus.busy),      32'(0));
            @(posedge clock);
            #1;
            check({tag, "/done_pulse"}, 32'(bus.done),      32'(0));
            check({tag, "/idle_after"}, 32'(bus.busy),      32'(0));
            check({tag, "/hold_hit"},   32'(bus.self_hit),  32'(e.self_hit));
            check({tag, "/hold_idx"},   32'(bus.hit_index), 32'(e.hit_index));
        end
    endtask

    initial begin
        int cnt;
        bus.start  = 1'b0;
        bus.length = '0;
        bus.food_x = '0;
        bus.food_y = '0;
        fill(0, 0, 0, 0);
        load_bus();

        repeat (3) @(posedge clock);
        #1;
        check("reset/outputs",
              32'({bus.busy, bus.done, bus.self_hit, bus.food_hit, bus.hit_index}), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Straight-line body, no hit, food elsewhere
        fill(320, 120, 0, 0);
        sx[1] = 319; sy[1] = 120;
        sx[2] = 318; sy[2] = 120;
        sx[3] = 317; sy[3] = 120;
        run_scan("straight", 3, 10, 10, -1);

        // Head revisited at segment 2
        fill(50, 50, 52, 50);
        sx[1] = 51;
        sx[2] = 50;
        run_scan("hit2", 5, 0, 0, -1);

        // Head only, sitting on food at the screen corner; segment 1 must be ignored
        fill(SCREEN_W - 1, SCREEN_H - 1, SCREEN_W - 1, SCREEN_H - 1);
        run_scan("len0_food", 0, SCREEN_W - 1, SCREEN_H - 1, -1);

        // Oversized length saturates; a start at cycle 10 must be dropped
        fill(2, 2, 1, 1);
        run_scan("clamp", 200, 2, 3, 10);

        // Match just beyond the valid body is not seen
        fill(7, 9, 0, 0);
        sx[3] = 7; sy[3] = 9;
        run_scan("beyond", 2, 0, 0, -1);

        // Match exactly at the last valid index
        fill(33, 44, 33, 45);
        sx[5] = 33; sy[5] = 44;
        run_scan("last_idx", 5, 33, 44, -1);

        // Two matches: the lower index wins
        fill(600, 400, 1, 2);
        sx[3] = 600; sy[3] = 400;
        sx[4] = 600; sy[4] = 400;
        run_scan("first_wins", 8, 5, 5, -1);

        // Hit at the final slot of a full-length snake
        fill(100, 200, 100, 201);
        sx[MAX_SEG-1] = 100; sy[MAX_SEG-1] = 200;
        run_scan("full_len", MAX_SEG - 1, 100, 200, -1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < MAX_SEG; k++) begin
                sx[k] = int'($urandom_range(0, 3));
                sy[k] = int'($urandom_range(0, 3));
            end
            run_scan($sformatf("rand%0d", r), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        // Abort a length-20 scan with reset at cycle 5
        fill(100, 100, 200, 200);
        @(negedge clock);
        load_bus();
        bus.length = LEN_W'(20);
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("abort/busy_before", 32'(bus.busy), 32'(1));
        reset_n = 1'b0;
        #1;
        check("abort/outputs",
              32'({bus.busy, bus.done, bus.self_hit, bus.food_hit, bus.hit_index}), 32'(0));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) cnt++;
        end
        check("abort/no_done", 32'(cnt), 32'(0));

        fill(9, 9, 1, 1);
        sx[4] = 9; sy[4] = 9;
        run_scan("post_reset", 20, 9, 9, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
